// File: rtl/keccak_pkg.sv
// Shared Keccak-f[1600] constants, lane type and lane index helper.
package keccak_pkg;

   localparam int unsigned LANE_W    = 64;
   localparam int unsigned NUM_LANES = 25;
   localparam int unsigned NUM_COLS  = 5;
   localparam int unsigned NUM_ROWS  = 5;

   typedef logic [LANE_W-1:0] lane_t;

   // Flat lane index of A[x,y]
   function automatic int unsigned lane_idx(input int unsigned x, input int unsigned y);
      return x + NUM_COLS * y;
   endfunction

endpackage

// File: rtl/theta_col_parity.sv
// Column parity of one Keccak column: XOR of its five lanes.
module theta_col_parity #(
   parameter int unsigned LANE_W = keccak_pkg::LANE_W
) (
   input  logic [LANE_W-1:0] i_lane_0,
   input  logic [LANE_W-1:0] i_lane_1,
   input  logic [LANE_W-1:0] i_lane_2,
   input  logic [LANE_W-1:0] i_lane_3,
   input  logic [LANE_W-1:0] i_lane_4,
   output logic [LANE_W-1:0] o_parity_c
);

   assign o_parity_c = i_lane_0 ^ i_lane_1 ^ i_lane_2 ^ i_lane_3 ^ i_lane_4;

endmodule

// File: rtl/theta.sv
// Keccak-f[1600] theta step with a single output register stage.
// Optional feature: define THETA_PARITY_OUT_EN to expose the registered
// column parities C[x] on out_parity_0 .. out_parity_4.
module theta
   import keccak_pkg::*;
#(
   parameter int unsigned LANE_W = keccak_pkg::LANE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [LANE_W-1:0] in_data_0,
   input  logic [LANE_W-1:0] in_data_1,
   input  logic [LANE_W-1:0] in_data_2,
   input  logic [LANE_W-1:0] in_data_3,
   input  logic [LANE_W-1:0] in_data_4,
   input  logic [LANE_W-1:0] in_data_5,
   input  logic [LANE_W-1:0] in_data_6,
   input  logic [LANE_W-1:0] in_data_7,
   input  logic [LANE_W-1:0] in_data_8,
   input  logic [LANE_W-1:0] in_data_9,
   input  logic [LANE_W-1:0] in_data_10,
   input  logic [LANE_W-1:0] in_data_11,
   input  logic [LANE_W-1:0] in_data_12,
   input  logic [LANE_W-1:0] in_data_13,
   input  logic [LANE_W-1:0] in_data_14,
   input  logic [LANE_W-1:0] in_data_15,
   input  logic [LANE_W-1:0] in_data_16,
   input  logic [LANE_W-1:0] in_data_17,
   input  logic [LANE_W-1:0] in_data_18,
   input  logic [LANE_W-1:0] in_data_19,
   input  logic [LANE_W-1:0] in_data_20,
   input  logic [LANE_W-1:0] in_data_21,
   input  logic [LANE_W-1:0] in_data_22,
   input  logic [LANE_W-1:0] in_data_23,
   input  logic [LANE_W-1:0] in_data_24,
   output logic              out_valid,
   output logic [LANE_W-1:0] out_data_0,
   output logic [LANE_W-1:0] out_data_1,
   output logic [LANE_W-1:0] out_data_2,
   output logic [LANE_W-1:0] out_data_3,
   output logic [LANE_W-1:0] out_data_4,
   output logic [LANE_W-1:0] out_data_5,
   output logic [LANE_W-1:0] out_data_6,
   output logic [LANE_W-1:0] out_data_7,
   output logic [LANE_W-1:0] out_data_8,
   output logic [LANE_W-1:0] out_data_9,
   output logic [LANE_W-1:0] out_data_10,
   output logic [LANE_W-1:0] out_data_11,
   output logic [LANE_W-1:0] out_data_12,
   output logic [LANE_W-1:0] out_data_13,
   output logic [LANE_W-1:0] out_data_14,
   output logic [LANE_W-1:0] out_data_15,
   output logic [LANE_W-1:0] out_data_16,
   output logic [LANE_W-1:0] out_data_17,
   output logic [LANE_W-1:0] out_data_18,
   output logic [LANE_W-1:0] out_data_19,
   output logic [LANE_W-1:0] out_data_20,
   output logic [LANE_W-1:0] out_data_21,
   output logic [LANE_W-1:0] out_data_22,
   output logic [LANE_W-1:0] out_data_23,
   output logic [LANE_W-1:0] out_data_24
`ifdef THETA_PARITY_OUT_EN
   ,
   output logic [LANE_W-1:0] out_parity_0,
   output logic [LANE_W-1:0] out_parity_1,
   output logic [LANE_W-1:0] out_parity_2,
   output logic [LANE_W-1:0] out_parity_3,
   output logic [LANE_W-1:0] out_parity_4
`endif
);

   logic [LANE_W-1:0] w_a  [NUM_LANES];  // input state A
   logic [LANE_W-1:0] w_c  [NUM_COLS];   // column parity C
   logic [LANE_W-1:0] w_d  [NUM_COLS];   // per-column mix D
   logic [LANE_W-1:0] w_ap [NUM_LANES];  // theta result A'

   logic              r_valid;
   logic [LANE_W-1:0] r_data [NUM_LANES];

   // Gather the flat input ports into a lane array
   assign w_a[0]  = in_data_0;
   assign w_a[1]  = in_data_1;
   assign w_a[2]  = in_data_2;
   assign w_a[3]  = in_data_3;
   assign w_a[4]  = in_data_4;
   assign w_a[5]  = in_data_5;
   assign w_a[6]  = in_data_6;
   assign w_a[7]  = in_data_7;
   assign w_a[8]  = in_data_8;
   assign w_a[9]  = in_data_9;
   assign w_a[10] = in_data_10;
   assign w_a[11] = in_data_11;
   assign w_a[12] = in_data_12;
   assign w_a[13] = in_data_13;
   assign w_a[14] = in_data_14;
   assign w_a[15] = in_data_15;
   assign w_a[16] = in_data_16;
   assign w_a[17] = in_data_17;
   assign w_a[18] = in_data_18;
   assign w_a[19] = in_data_19;
   assign w_a[20] = in_data_20;
   assign w_a[21] = in_data_21;
   assign w_a[22] = in_data_22;
   assign w_a[23] = in_data_23;
   assign w_a[24] = in_data_24;

   // Column parity, then D[x] = C[x-1] ^ ROTL(C[x+1], 1)
   for (genvar gx = 0; gx < NUM_COLS; gx++) begin : g_col
      theta_col_parity #(
         .LANE_W (LANE_W)
      ) u_col_parity (
         .i_lane_0   (w_a[lane_idx(gx, 0)]),
         .i_lane_1   (w_a[lane_idx(gx, 1)]),
         .i_lane_2   (w_a[lane_idx(gx, 2)]),
         .i_lane_3   (w_a[lane_idx(gx, 3)]),
         .i_lane_4   (w_a[lane_idx(gx, 4)]),
         .o_parity_c (w_c[gx])
      );

      assign w_d[gx] = w_c[(gx + 4) % 5]
                     ^ {w_c[(gx + 1) % 5][LANE_W-2:0], w_c[(gx + 1) % 5][LANE_W-1]};
   end

   // Every lane in column x absorbs D[x]
   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign w_ap[gi] = w_a[gi] ^ w_d[gi % 5];
   end

   // Output stage: valid follows in_valid, data loads only on valid input
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         for (int i = 0; i < NUM_LANES; i++) r_data[i] <= '0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            for (int i = 0; i < NUM_LANES; i++) r_data[i] <= w_ap[i];
         end
      end
   end

   assign out_valid   = r_valid;
   assign out_data_0  = r_data[0];
   assign out_data_1  = r_data[1];
   assign out_data_2  = r_data[2];
   assign out_data_3  = r_data[3];
   assign out_data_4  = r_data[4];
   assign out_data_5  = r_data[5];
   assign out_data_6  = r_data[6];
   assign out_data_7  = r_data[7];
   assign out_data_8  = r_data[8];
   assign out_data_9  = r_data[9];
   assign out_data_10 = r_data[10];
   assign out_data_11 = r_data[11];
   assign out_data_12 = r_data[12];
   assign out_data_13 = r_data[13];
   assign out_data_14 = r_data[14];
   assign out_data_15 = r_data[15];
   assign out_data_16 = r_data[16];
   assign out_data_17 = r_data[17];
   assign out_data_18 = r_data[18];
   assign out_data_19 = r_data[19];
   assign out_data_20 = r_data[20];
   assign out_data_21 = r_data[21];
   assign out_data_22 = r_data[22];
   assign out_data_23 = r_data[23];
   assign out_data_24 = r_data[24];

`ifdef THETA_PARITY_OUT_EN
   logic [LANE_W-1:0] r_parity [NUM_COLS];

   // Column parities registered alongside the state lanes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int x = 0; x < NUM_COLS; x++) r_parity[x] <= '0;
      end else if (in_valid) begin
         for (int x = 0; x < NUM_COLS; x++) r_parity[x] <= w_c[x];
      end
   end

   assign out_parity_0 = r_parity[0];
   assign out_parity_1 = r_parity[1];
   assign out_parity_2 = r_parity[2];
   assign out_parity_3 = r_parity[3];
   assign out_parity_4 = r_parity[4];
`endif

endmodule

// File: tb/tb_theta.sv
// Self-checking bench for theta: directed vectors, random streaming, resets.
module tb_theta;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [63:0] in_d  [25];
   logic [63:0] out_d [25];
   logic        out_valid;
`ifdef THETA_PARITY_OUT_EN
   logic [63:0] out_p [5];
`endif

   logic [63:0] m_out [25];
   logic [63:0] m_par [5];
   logic [63:0] exp_d [25];
   logic [63:0] exp_p [5];
   logic        exp_valid;

   int checks = 0;
   int errors = 0;

   theta dut (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .in_data_0(in_d[0]),   .in_data_1(in_d[1]),   .in_data_2(in_d[2]),
      .in_data_3(in_d[3]),   .in_data_4(in_d[4]),   .in_data_5(in_d[5]),
      .in_data_6(in_d[6]),   .in_data_7(in_d[7]),   .in_data_8(in_d[8]),
      .in_data_9(in_d[9]),   .in_data_10(in_d[10]), .in_data_11(in_d[11]),
      .in_data_12(in_d[12]), .in_data_13(in_d[13]), .in_data_14(in_d[14]),
      .in_data_15(in_d[15]), .in_data_16(in_d[16]), .in_data_17(in_d[17]),
      .in_data_18(in_d[18]), .in_data_19(in_d[19]), .in_data_20(in_d[20]),
      .in_data_21(in_d[21]), .in_data_22(in_d[22]), .in_data_23(in_d[23]),
      .in_data_24(in_d[24]),
      .out_valid(out_valid),
      .out_data_0(out_d[0]),   .out_data_1(out_d[1]),   .out_data_2(out_d[2]),
      .out_data_3(out_d[3]),   .out_data_4(out_d[4]),   .out_data_5(out_d[5]),
      .out_data_6(out_d[6]),   .out_data_7(out_d[7]),   .out_data_8(out_d[8]),
      .out_data_9(out_d[9]),   .out_data_10(out_d[10]), .out_data_11(out_d[11]),
      .out_data_12(out_d[12]), .out_data_13(out_d[13]), .out_data_14(out_d[14]),
      .out_data_15(out_d[15]), .out_data_16(out_d[16]), .out_data_17(out_d[17]),
      .out_data_18(out_d[18]), .out_data_19(out_d[19]), .out_data_20(out_d[20]),
      .out_data_21(out_d[21]), .out_data_22(out_d[22]), .out_data_23(out_d[23]),
      .out_data_24(out_d[24])
`ifdef THETA_PARITY_OUT_EN
      ,
      .out_parity_0(out_p[0]), .out_parity_1(out_p[1]), .out_parity_2(out_p[2]),
      .out_parity_3(out_p[3]), .out_parity_4(out_p[4])
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts and reports
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Bit-level theta: each output bit flips by the parity of the column to the
   // left at the same depth and the column to the right one bit shallower
   task automatic model();
      logic [63:0] col [5];
      for (int x = 0; x < 5; x++) begin
         col[x] = 64'd0;
         for (int z = 0; z < 64; z++) begin
            logic p;
            p = 1'b0;
            for (int y = 0; y < 5; y++) p = p ^ in_d[x + 5*y][z];
            col[x][z] = p;
         end
         m_par[x] = col[x];
      end
      for (int x = 0; x < 5; x++)
         for (int y = 0; y < 5; y++)
            for (int z = 0; z < 64; z++)
               m_out[x + 5*y][z] = in_d[x + 5*y][z] ^ col[(x + 4) % 5][z]
                                   ^ col[(x + 1) % 5][(z + 63) % 64];
   endtask

   task automatic clear_expect();
      exp_valid = 1'b0;
      for (int i = 0; i < 25; i++) exp_d[i] = 64'd0;
      for (int x = 0; x < 5; x++) exp_p[x] = 64'd0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".valid"}, {63'd0, out_valid}, {63'd0, exp_valid});
      for (int i = 0; i < 25; i++)
         check($sformatf("%s.lane%0d", tag, i), out_d[i], exp_d[i]);
`ifdef THETA_PARITY_OUT_EN
      for (int x = 0; x < 5; x++)
         check($sformatf("%s.par%0d", tag, x), out_p[x], exp_p[x]);
`endif
   endtask

   // One clock: update expectation from current inputs, then sample after edge
   task automatic cycle(input string tag);
      model();
      if (rst) begin
         clear_expect();
      end else begin
         if (in_valid) begin
            for (int i = 0; i < 25; i++) exp_d[i] = m_out[i];
            for (int x = 0; x < 5; x++) exp_p[x] = m_par[x];
         end
         exp_valid = in_valid;
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic set_all(input logic [63:0] v);
      for (int i = 0; i < 25; i++) in_d[i] = v;
   endtask

   task automatic set_rand();
      for (int i = 0; i < 25; i++) in_d[i] = {$urandom(), $urandom()};
   endtask

   initial begin
      logic [63:0] e;
      rst      = 1'b0;
      in_valid = 1'b0;
      set_all(64'd0);
      clear_expect();
      #2 rst = 1'b1;
      #1 check_all("reset");

      // Reset dominates a valid input with random data
      in_valid = 1'b1;
      set_rand();
      cycle("rst_busy");
      cycle("rst_busy2");
      rst      = 1'b0;
      in_valid = 1'b0;
      cycle("post_rst_idle");
      in_valid = 1'b1;
      set_all(64'd0);
      cycle("zero");

      // Single bit in lane 0
      set_all(64'd0);
      in_d[0] = 64'h1;
      cycle("bit0");
      for (int i = 0; i < 25; i++) begin
         e = 64'd0;
         if (i == 0 || i % 5 == 1) e = 64'h1;
         if (i % 5 == 4) e = 64'h2;
         check($sformatf("bit0_const.lane%0d", i), out_d[i], e);
      end

      // Top bit in lane 2 exercises the rotation wrap
      set_all(64'd0);
      in_d[2] = 64'h8000_0000_0000_0000;
      cycle("wrap");
      for (int i = 0; i < 25; i++) begin
         e = 64'd0;
         if (i == 2 || i % 5 == 3) e = 64'h8000_0000_0000_0000;
         if (i % 5 == 1) e = 64'h1;
         check($sformatf("wrap_const.lane%0d", i), out_d[i], e);
      end

      // All ones: every column parity is all ones, so D is zero
      set_all(64'hFFFF_FFFF_FFFF_FFFF);
      cycle("ones");
      for (int i = 0; i < 25; i++)
         check($sformatf("ones_const.lane%0d", i), out_d[i], 64'hFFFF_FFFF_FFFF_FFFF);

      // Idle cycle with changed inputs: outputs hold
      in_valid = 1'b0;
      set_rand();
      cycle("hold");

      // Back-to-back random states
      in_valid = 1'b1;
      for (int n = 0; n < 100; n++) begin
         set_rand();
         cycle($sformatf("stream%0d", n));
      end

      // Random gaps
      for (int n = 0; n < 30; n++) begin
         in_valid = 1'($urandom_range(0, 1));
         set_rand();
         cycle($sformatf("gap%0d", n));
      end

      // Mid-stream asynchronous reset discards state in flight
      in_valid = 1'b1;
      set_rand();
      cycle("pre_mid_rst");
      set_rand();
      #2 rst = 1'b1;
      #1;
      clear_expect();
      check_all("mid_rst_async");
      cycle("mid_rst_edge");
      rst = 1'b0;
      in_valid = 1'b0;
      cycle("mid_rst_idle");
      in_valid = 1'b1;
      set_rand();
      cycle("mid_rst_first");
      in_valid = 1'b0;
      cycle("mid_rst_hold");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
